// File: rtl/lot_pkg.sv
// Shared types and default sizing for the parking-lot barrier arbiter.
package lot_pkg;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      GRANT_IN  = 2'd1,
      GRANT_OUT = 2'd2,
      CLEAR     = 2'd3
   } lot_state_t;

   localparam int LOT_WIDTH    = 5;
   localparam int LOT_CAPACITY = 25;
   localparam int LOT_TIMEOUT  = 16;

endpackage

// File: rtl/gate_timer.sv
// Grant watchdog: counts cycles while run is high and flags the final allowed cycle.
module gate_timer
   import lot_pkg::*;
#(
   parameter int TIMEOUT = LOT_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Count restarts at zero on every grant because run drops in CLEAR/IDLE.
   always_comb begin
      cnt_d = '0;
      if (run && !clear) cnt_d = cnt_q + 1'b1;
   end

   assign expired = run && !clear && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/lot_gate_arbiter.sv
// Shared-barrier arbiter for a parking lot entry/exit lane pair with occupancy tracking.
// Optional grant watchdog enabled by defining GATE_TIMEOUT_EN.
module lot_gate_arbiter
   import lot_pkg::*;
#(
   parameter int WIDTH    = LOT_WIDTH,
   parameter int CAPACITY = LOT_CAPACITY,
   parameter int TIMEOUT  = LOT_TIMEOUT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             entry_req,
   input  logic             exit_req,
   input  logic             enter_done,
   input  logic             exit_done,
   output logic             grant_in,
   output logic             grant_out,
   output logic [WIDTH-1:0] occupancy,
   output logic             full,
   output logic             empty,
   output logic             timeout_err
);

   localparam logic [WIDTH-1:0] CAP_V = WIDTH'(CAPACITY);

   lot_state_t       state_q;
   logic [WIDTH-1:0] occ_q, occ_d;
   logic             grant_in_q, grant_out_q, terr_q;
   logic             last_out_q;
   logic             qual_in, qual_out, pick_out;
   logic             done_hit, expired;

   assign full  = (occ_q == CAP_V);
   assign empty = (occ_q == '0);

   assign qual_in  = entry_req & ~full;
   assign qual_out = exit_req & ~empty;
   // Exit takes a tie unless it was the last direction served.
   assign pick_out = qual_out & (~qual_in | ~last_out_q);

   assign done_hit = ((state_q == GRANT_IN) && enter_done) ||
                     ((state_q == GRANT_OUT) && exit_done);

   always_comb begin
      occ_d = occ_q;
      if (state_q == GRANT_IN && enter_done && occ_q != CAP_V) occ_d = occ_q + 1'b1;
      if (state_q == GRANT_OUT && exit_done && occ_q != '0)    occ_d = occ_q - 1'b1;
   end

`ifdef GATE_TIMEOUT_EN
   gate_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .run     ((state_q == GRANT_IN) || (state_q == GRANT_OUT)),
      .clear   (done_hit),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         occ_q       <= '0;
         grant_in_q  <= 1'b0;
         grant_out_q <= 1'b0;
         terr_q      <= 1'b0;
         last_out_q  <= 1'b0;
      end else begin
         terr_q <= 1'b0;
         occ_q  <= occ_d;
         case (state_q)
            IDLE: begin
               if (pick_out) begin
                  state_q     <= GRANT_OUT;
                  grant_out_q <= 1'b1;
                  last_out_q  <= 1'b1;
               end else if (qual_in) begin
                  state_q    <= GRANT_IN;
                  grant_in_q <= 1'b1;
                  last_out_q <= 1'b0;
               end
            end
            GRANT_IN, GRANT_OUT: begin
               // A matching done on the expiry cycle counts as a normal completion.
               if (done_hit || expired) begin
                  state_q     <= CLEAR;
                  grant_in_q  <= 1'b0;
                  grant_out_q <= 1'b0;
                  terr_q      <= ~done_hit;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign grant_in    = grant_in_q;
   assign grant_out   = grant_out_q;
   assign occupancy   = occ_q;
   assign timeout_err = terr_q;

endmodule
